// File: rtl/game2048_if.sv
// game2048_if: move-command and board-status bundle of the 2048 engine.
//   master (key-input side / bench): drives move_valid, move_dir; observes the rest.
//   slave  (game2048_engine):        drives move_ready, board, score, done, moved, won, lost.
//   board packs cell(r,c) at [(r*N+c)*TW +: TW], r0 top row, c0 left column.
interface game2048_if #(
  parameter int N  = 4,
  parameter int TW = 4
);
  logic                move_valid;
  logic [1:0]          move_dir;   // 0 up, 1 down, 2 left, 3 right
  logic                move_ready;
  logic [N*N*TW-1:0]   board;
  logic [31:0]         score;
  logic                done;
  logic                moved;
  logic                won;
  logic                lost;

  modport master (
    output move_valid, move_dir,
    input  move_ready, board, score, done, moved, won, lost
  );

  modport slave (
    input  move_valid, move_dir,
    output move_ready, board, score, done, moved, won, lost
  );
endinterface

// File: rtl/game2048_engine.sv
// game2048_engine: sequential 2048 game core.
//   Holds an NxN board of tile exponents (0 = empty). A move accepted in IDLE slides
//   and merges one line per cycle (SLIDE, N cycles), spawns one tile from a 16-bit
//   LFSR (GEN), then updates won/lost and pulses done (CHECK). A lost board parks in
//   OVER until reset.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, dominates every state
//   bus  - game2048_if.slave: move_valid/move_dir in; move_ready, board, score,
//          done (1-cycle pulse), moved (valid with done), won/lost (sticky) out
module game2048_engine #(
  parameter int          N       = 4,
  parameter int          TW      = 4,
  parameter int          WIN_EXP = 11,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic      clk,
  input  logic      rst,
  game2048_if.slave bus
);
  localparam int                  CELLS      = N * N;
  localparam int                  LW         = (N > 1) ? $clog2(N) : 1;
  localparam logic [TW-1:0]       EMAX       = {TW{1'b1}};
  localparam logic [31:0]         WIN_L      = 32'(WIN_EXP);
  localparam logic [CELLS*TW-1:0] BOARD_INIT = {{(CELLS*TW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0]       LINE_LAST  = LW'(N - 1);

  typedef enum logic [2:0] {S_IDLE, S_SLIDE, S_GEN, S_CHECK, S_OVER} state_e;

  state_e              state_q, state_d;
  logic [CELLS*TW-1:0] board_q, board_d;
  logic [31:0]         score_q, score_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [1:0]          dir_q, dir_d;
  logic [LW-1:0]       line_q, line_d;
  logic                mflag_q, mflag_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                moved_q, moved_d;
  logic                won_q, won_d;
  logic                lost_q, lost_d;

  int                  line_idx [N];
  logic [TW-1:0]       line_in  [N];
  logic [TW-1:0]       line_out [N];
  logic [31:0]         gain;
  logic                line_chg;
  int                  wr;
  logic                have;
  logic [TW-1:0]       pend;

  logic [7:0]          e_cnt;
  logic [7:0]          seen;
  logic [15:0]         k_sel;
  int                  spawn_idx;
  logic [TW-1:0]       spawn_val;
  logic                any_win, has_zero, has_pair;

  function automatic logic [TW-1:0] cell_at(input logic [CELLS*TW-1:0] b, input int i);
    return b[i*TW +: TW];
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11 (shift right, feedback into bit 15).
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // Cell indices of the current line, ordered from the leading edge of the move.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      case (dir_q)
        2'd0:    line_idx[j] = j * N + int'(line_q);
        2'd1:    line_idx[j] = (N - 1 - j) * N + int'(line_q);
        2'd2:    line_idx[j] = int'(line_q) * N + j;
        default: line_idx[j] = int'(line_q) * N + (N - 1 - j);
      endcase
      line_in[j] = cell_at(board_q, line_idx[j]);
    end
  end

  // Compact toward the leading edge; a held tile merges only with the next non-zero one.
  always_comb begin
    gain     = 32'd0;
    wr       = 0;
    have     = 1'b0;
    pend     = {TW{1'b0}};
    line_chg = 1'b0;
    for (int j = 0; j < N; j++) begin
      line_out[j] = {TW{1'b0}};
    end
    for (int j = 0; j < N; j++) begin
      if (line_in[j] == {TW{1'b0}}) begin
        have = have;
      end else if (have && (pend == line_in[j])) begin
        // Saturated pairs still merge and still score 2^(e+1).
        line_out[wr] = (pend == EMAX) ? EMAX : pend + TW'(1);
        gain         = gain + (32'd1 << (32'(pend) + 32'd1));
        wr           = wr + 1;
        have         = 1'b0;
      end else begin
        if (have) begin
          line_out[wr] = pend;
          wr           = wr + 1;
        end else begin
          wr = wr;
        end
        pend = line_in[j];
        have = 1'b1;
      end
    end
    if (have) begin
      line_out[wr] = pend;
    end else begin
      wr = wr;
    end
    for (int j = 0; j < N; j++) begin
      if (line_out[j] != line_in[j]) begin
        line_chg = 1'b1;
      end else begin
        line_chg = line_chg;
      end
    end
  end

  // Empty-cell count, row-major spawn position and end-of-move board checks.
  always_comb begin
    e_cnt     = 8'd0;
    seen      = 8'd0;
    spawn_idx = 0;
    any_win   = 1'b0;
    has_zero  = 1'b0;
    has_pair  = 1'b0;
    for (int i = 0; i < CELLS; i++) begin
      if (cell_at(board_q, i) == {TW{1'b0}}) begin
        e_cnt = e_cnt + 8'd1;
      end else begin
        e_cnt = e_cnt;
      end
    end
    k_sel = (e_cnt == 8'd0) ? 16'd0 : (lfsr_q % {8'd0, e_cnt});
    for (int i = 0; i < CELLS; i++) begin
      if (cell_at(board_q, i) == {TW{1'b0}}) begin
        if ({8'd0, seen} == k_sel) begin
          spawn_idx = i;
        end else begin
          spawn_idx = spawn_idx;
        end
        seen = seen + 8'd1;
      end else begin
        seen = seen;
      end
    end
    spawn_val = (lfsr_q[15:12] == 4'd0) ? TW'(2) : TW'(1);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (32'(cell_at(board_q, r * N + c)) >= WIN_L) any_win = 1'b1;
        else any_win = any_win;
        if (cell_at(board_q, r * N + c) == {TW{1'b0}}) has_zero = 1'b1;
        else has_zero = has_zero;
        if ((c < N - 1) && (cell_at(board_q, r * N + c) == cell_at(board_q, r * N + c + 1))) has_pair = 1'b1;
        else has_pair = has_pair;
        if ((r < N - 1) && (cell_at(board_q, r * N + c) == cell_at(board_q, (r + 1) * N + c))) has_pair = 1'b1;
        else has_pair = has_pair;
      end
    end
  end

  // Next-state and datapath update for every register.
  always_comb begin
    state_d = state_q;
    board_d = board_q;
    score_d = score_q;
    lfsr_d  = lfsr_step(lfsr_q);
    dir_d   = dir_q;
    line_d  = line_q;
    mflag_d = mflag_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    moved_d = 1'b0;
    won_d   = won_q;
    lost_d  = lost_q;
    case (state_q)
      S_IDLE: begin
        if (bus.move_valid) begin
          dir_d   = bus.move_dir;
          line_d  = {LW{1'b0}};
          mflag_d = 1'b0;
          ready_d = 1'b0;
          state_d = S_SLIDE;
        end else begin
          ready_d = 1'b1;
        end
      end
      S_SLIDE: begin
        for (int j = 0; j < N; j++) begin
          board_d[line_idx[j]*TW +: TW] = line_out[j];
        end
        score_d = score_q + gain;
        mflag_d = mflag_q | line_chg;
        if (line_q == LINE_LAST) begin
          state_d = S_GEN;
        end else begin
          line_d = line_q + LW'(1);
        end
      end
      S_GEN: begin
        if (mflag_q && (e_cnt != 8'd0)) begin
          board_d[spawn_idx*TW +: TW] = spawn_val;
        end else begin
          board_d = board_q;
        end
        state_d = S_CHECK;
      end
      S_CHECK: begin
        won_d   = won_q | any_win;
        lost_d  = lost_q | (~has_zero & ~has_pair);
        done_d  = 1'b1;
        moved_d = mflag_q;
        if (~has_zero & ~has_pair) begin
          state_d = S_OVER;
          ready_d = 1'b0;
        end else begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end
      end
      S_OVER: begin
        ready_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      board_q <= BOARD_INIT;
      score_q <= 32'd0;
      lfsr_q  <= SEED;
      dir_q   <= 2'd0;
      line_q  <= {LW{1'b0}};
      mflag_q <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      moved_q <= 1'b0;
      won_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      score_q <= score_d;
      lfsr_q  <= lfsr_d;
      dir_q   <= dir_d;
      line_q  <= line_d;
      mflag_q <= mflag_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      moved_q <= moved_d;
      won_q   <= won_d;
      lost_q  <= lost_d;
    end
  end

  assign bus.move_ready = ready_q;
  assign bus.board      = board_q;
  assign bus.score      = score_q;
  assign bus.done       = done_q;
  assign bus.moved      = moved_q;
  assign bus.won        = won_q;
  assign bus.lost       = lost_q;
endmodule

// File: tb/tb_game2048_engine.sv
// tb_game2048_engine: random play against a queue-based 2048 reference model.
module tb_game2048_engine;
  localparam int          N    = 3;
  localparam int          TW   = 4;
  localparam int          WIN  = 4;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          MAXE = (1 << TW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  game2048_if #(.N(N), .TW(TW)) bus ();

  game2048_engine #(.N(N), .TW(TW), .WIN_EXP(WIN), .SEED(SEED)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference LFSR: reloads on a reset edge, otherwise steps every clock.
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  int          mb [N][N];
  logic [31:0] m_score;
  bit          m_won, m_lost, m_moved;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*N*TW-1:0] pack_board();
    logic [N*N*TW-1:0] b;
    b = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        b[(r*N+c)*TW +: TW] = TW'(mb[r][c]);
    return b;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mb[r][c] = 0;
    mb[0][0] = 1;
    m_score  = 32'd0;
    m_won    = 1'b0;
    m_lost   = 1'b0;
  endtask

  // Position j of line l, counted from the edge the tiles move toward.
  function automatic void line_pos(input int dir, input int l, input int j, output int r, output int c);
    case (dir)
      0:       begin r = j;         c = l;         end
      1:       begin r = N - 1 - j; c = l;         end
      2:       begin r = l;         c = j;         end
      default: begin r = l;         c = N - 1 - j; end
    endcase
  endfunction

  task automatic model_move(input int dir, input logic [15:0] lf);
    int q[$];
    int o[$];
    int empt[$];
    int r, c, i, k, v;
    bit pair, zero;
    m_moved = 1'b0;
    for (int l = 0; l < N; l++) begin
      q.delete();
      o.delete();
      for (int j = 0; j < N; j++) begin
        line_pos(dir, l, j, r, c);
        if (mb[r][c] != 0) q.push_back(mb[r][c]);
      end
      i = 0;
      while (i < q.size()) begin
        if (i + 1 < q.size() && q[i] == q[i+1]) begin
          o.push_back((q[i] + 1 > MAXE) ? MAXE : q[i] + 1);
          m_score = m_score + (32'd1 << (q[i] + 1));
          i += 2;
        end else begin
          o.push_back(q[i]);
          i += 1;
        end
      end
      while (o.size() < N) o.push_back(0);
      for (int j = 0; j < N; j++) begin
        line_pos(dir, l, j, r, c);
        if (mb[r][c] != o[j]) m_moved = 1'b1;
        mb[r][c] = o[j];
      end
    end
    if (m_moved) begin
      for (int rr = 0; rr < N; rr++)
        for (int cc = 0; cc < N; cc++)
          if (mb[rr][cc] == 0) empt.push_back(rr * N + cc);
      if (empt.size() > 0) begin
        k = int'(lf) % empt.size();
        v = (lf[15:12] == 4'd0) ? 2 : 1;
        mb[empt[k] / N][empt[k] % N] = v;
      end
    end
    pair = 1'b0;
    zero = 1'b0;
    for (int rr = 0; rr < N; rr++)
      for (int cc = 0; cc < N; cc++) begin
        if (mb[rr][cc] >= WIN) m_won = 1'b1;
        if (mb[rr][cc] == 0) zero = 1'b1;
        if (cc + 1 < N && mb[rr][cc] == mb[rr][cc+1]) pair = 1'b1;
        if (rr + 1 < N && mb[rr][cc] == mb[rr+1][cc]) pair = 1'b1;
      end
    if (!zero && !pair) m_lost = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_board"}, bus.board, pack_board());
    check_eq({tag, "_score"}, bus.score, 64'd0);
    check_eq({tag, "_ready"}, bus.move_ready, 64'd1);
    check_eq({tag, "_done"},  bus.done, 64'd0);
    check_eq({tag, "_won"},   bus.won, 64'd0);
    check_eq({tag, "_lost"},  bus.lost, 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    bus.move_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_reset_state("reset");
  endtask

  task automatic do_move(input int dir);
    logic [15:0] lf;
    lf = 16'd0;
    @(negedge clk);
    check_eq("ready_idle", bus.move_ready, 64'd1);
    bus.move_valid = 1'b1;
    bus.move_dir   = 2'(dir);
    @(negedge clk);
    bus.move_valid = 1'b0;
    bus.move_dir   = 2'($urandom);
    for (int cyc = 1; cyc <= N + 2; cyc++) begin
      @(negedge clk);
      if (cyc == N) lf = m_lfsr;
      if (cyc < N + 2) begin
        check_eq("busy_done", bus.done, 64'd0);
        check_eq("busy_ready", bus.move_ready, 64'd0);
      end
    end
    model_move(dir, lf);
    check_eq("done", bus.done, 64'd1);
    check_eq("moved", bus.moved, 64'(m_moved));
    check_eq("board", bus.board, pack_board());
    check_eq("score", bus.score, 64'(m_score));
    check_eq("won", bus.won, 64'(m_won));
    check_eq("lost", bus.lost, 64'(m_lost));
    check_eq("ready_after", bus.move_ready, 64'(!m_lost));
  endtask

  task automatic over_check();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.move_valid = 1'b1;
      bus.move_dir   = 2'($urandom);
      @(negedge clk);
      check_eq("over_ready", bus.move_ready, 64'd0);
      check_eq("over_done", bus.done, 64'd0);
      check_eq("over_board", bus.board, pack_board());
      check_eq("over_score", bus.score, 64'(m_score));
      check_eq("over_lost", bus.lost, 64'd1);
    end
    bus.move_valid = 1'b0;
  endtask

  task automatic mid_slide_reset();
    @(negedge clk);
    bus.move_valid = 1'b1;
    bus.move_dir   = 2'd3;
    @(negedge clk);
    bus.move_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_reset_state("midslide_rst");
  endtask

  initial begin
    int moves;
    bus.move_valid = 1'b0;
    bus.move_dir   = 2'd0;
    do_reset();
    do_move(2);
    check_eq("noop_left_moved", bus.moved, 64'd0);
    do_move(0);
    check_eq("noop_up_moved", bus.moved, 64'd0);
    do_move(3);
    check_eq("right_moved", bus.moved, 64'd1);
    for (int game = 0; game < 4; game++) begin
      moves = 0;
      while (!m_lost && moves < 300) begin
        do_move($urandom_range(0, 3));
        moves++;
      end
      if (m_lost) over_check();
      mid_slide_reset();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
